mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer for the shared single-port instruction/data memory. The memory has one bidirectional data port and separate rd/wr strobes, so it cannot read and write at the same time. This block serialises two requesters onto it: the fetch unit (port A, read-only) and the load/store unit (port B, read/write). It sits between the CPU front/back end and the memory, owns mem_rd, mem_wr, mem_addr and the data-bus drive, and uses round-robin arbitration.

## Interface
Parameters:
- AWIDTH, 5, memory address width
- DWIDTH, 8, memory data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- a_req  in  1  fetch request, held high until a_ack
- a_addr  in  AWIDTH  fetch address, stable while a_req high
- a_rdata  out  DWIDTH  fetch read data, valid in the a_ack cycle
- a_ack  out  1  one-cycle completion pulse for port A
- b_req  in  1  load/store request, held high until b_ack
- b_we  in  1  1 = write, 0 = read; stable while b_req high
- b_addr  in  AWIDTH  load/store address
- b_wdata  in  DWIDTH  store data
- b_rdata  out  DWIDTH  load data, valid in the b_ack cycle
- b_ack  out  1  one-cycle completion pulse for port B
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AWIDTH  memory address
- mem_data  inout  DWIDTH  memory data bus; driven by this block only while mem_wr=1, else high-Z

## Operation
- FSM states: IDLE, ACCESS, ACK. Reset state is IDLE.
- IDLE:
  - If any req is high, latch the winner's index, address, we and wdata, then go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration is 2-way round-robin.
  - If only one req is high, it wins.
  - If both are high, the port not granted last wins.
  - After reset the last-grant pointer points at B, so A wins the first tie.
  - The pointer updates only when a grant is issued.
- ACCESS:
  - mem_addr = latched address.
  - mem_rd = 1 for a read (any A grant, or B with we=0).
  - mem_wr = 1 for a B write, and mem_data is driven with the latched wdata.
  - mem_rd and mem_wr are never high together.
  - At the end of the cycle: a read captures mem_data into the granted port's rdata register; a write is committed by the memory on that edge.
  - Next state is ACK.
- ACK:
  - The granted port's ack = 1. Memory strobes are low.
  - Next state is IDLE unconditionally. Requests are not sampled in ACK.
- Requesters drop req on the edge after seeing ack. A req still high in IDLE is treated as a new request.
- rdata registers hold their value until the next read completes on the same port.
- The non-granted port's ack stays 0. Its rdata is unchanged.
- Addresses are used unmodified. No wrap or range checking, since an AWIDTH address always covers the full depth.

## Timing
- Reset values:
  - state = IDLE, last-grant pointer = B.
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0.
  - mem_rd = mem_wr = 0, mem_addr = 0, mem_data = Z.
- Latency: req high in IDLE at cycle N → ACCESS at N+1 → ack and rdata valid at N+2.
- Throughput: at most one access per 3 cycles. With both ports continuously requesting, grants alternate A, B, A, B.
- A request arriving during ACCESS or ACK waits until the next IDLE.
- Reset mid-operation (in ACCESS or ACK):
  - Next cycle is IDLE with all strobes and acks low.
  - No ack is issued for the aborted transaction.
  - A write that reached the ACCESS edge together with rst is superseded by the memory's own reset clear.
- mem_rd, mem_wr and mem_addr decode combinationally from registered state and latched fields only, never from live req inputs. They are glitch-free with respect to requester changes.

## Structure
- Shared header mem_arb_defs.vh contains:
  - state encodings: IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2;
  - port index constants: PORT_A = 1'b0, PORT_B = 1'b1.
- One sub-module, rr_pick2:
  - inputs: req[1:0], last-grant;
  - outputs: grant_valid, grant_idx.
  - Purely combinational; the last-grant register lives in mem_arbiter.
- mem_arbiter holds the FSM, the latch registers, the rdata registers and the tri-state driver.

## Test plan
- Reset release, then a_req=1, a_addr=5'h03 with memory[3]=8'hA5 → mem_rd high one cycle with mem_addr=3; a_ack pulses 2 cycles after req; a_rdata=8'hA5; b_ack stays 0.
- b_req=1, b_we=1, b_addr=5'h1F, b_wdata=8'h3C → one ACCESS cycle with mem_wr=1, mem_rd=0 and mem_data driven to 8'h3C; b_ack follows; a subsequent B read of 5'h1F returns 8'h3C.
- Both reqs asserted together right after reset and held → grant order A, B, A, B; each ack arrives 3 cycles after the previous one; mem_data is Z in every non-write cycle.
- b_req raised during A's ACCESS cycle → B is not granted until the IDLE after a_ack; b_ack arrives 3 cycles after a_ack.
- rst asserted in ACCESS of a B read → no b_ack; next cycle IDLE with mem_rd=0; b_rdata=0.
- A req held high one cycle past ack (protocol violation) → treated as a second request; a second a_ack follows 3 cycles later; no deadlock.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t   : sequencer states (IDLE, ACCESS, ACK)
//   PORT_A/B  : requester index encoding used for grants and the
//               last-grant pointer (A = fetch, B = load/store)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0]    in   request vector, bit 0 = port A, bit 1 = port B
//   last_grant  in   index of the port granted most recently
//   grant_valid out  at least one request is pending
//   grant_idx   out  index of the winning port
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_A;
        if (req[0] && req[1]) begin
            // Tie: the port that did not win last time goes next.
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer serialising a fetch port (A, read-only) and a
// load/store port (B, read/write) onto a single-port memory with a shared
// bidirectional data bus. Each access takes IDLE -> ACCESS -> ACK.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   a_req, a_addr                fetch request and address
//   a_rdata, a_ack               fetch data and one-cycle completion pulse
//   b_req, b_we, b_addr, b_wdata load/store request, direction, address, data
//   b_rdata, b_ack               load data and one-cycle completion pulse
//   mem_rd, mem_wr, mem_addr     memory strobes and address
//   mem_data                     memory data bus, driven only during a write
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [AWIDTH-1:0] a_addr,
    output logic [DWIDTH-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic [DWIDTH-1:0] b_rdata,
    output logic              b_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              r_idx;
    logic              r_we;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_a_rdata;
    logic [DWIDTH-1:0] r_b_rdata;

    logic              w_grant_valid;
    logic              w_grant_idx;
    logic              w_take;
    logic              w_rd;
    logic              w_wr;

    rr_pick2 u_pick (
        .req         ({b_req, a_req}),
        .last_grant  (r_last),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Next state and strobe decode, from registered state and latched fields only.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        mem_addr    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr    = r_addr;
                w_wr        = (r_idx == PORT_B) && r_we;
                w_rd        = !w_wr;
                w_state_nxt = ACK;
            end
            ACK: begin
                a_ack       = (r_idx == PORT_A);
                b_ack       = (r_idx == PORT_B);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= PORT_B;
            r_idx   <= PORT_A;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_last <= w_grant_idx;
                r_idx  <= w_grant_idx;
                // Port A is read-only, so its grant never carries a write.
                r_we   <= (w_grant_idx == PORT_B) && b_we;
            end
        end
    end

    // Latched address/data need no reset: they are only observed in ACCESS.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_addr  <= (w_grant_idx == PORT_B) ? b_addr : a_addr;
            r_wdata <= b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if (w_rd) begin
            if (r_idx == PORT_A) r_a_rdata <= mem_data;
            else                 r_b_rdata <= mem_data;
        end
    end

    assign mem_rd   = w_rd;
    assign mem_wr   = w_wr;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign mem_data = w_wr ? r_wdata : {DWIDTH{1'bz}};

endmodule
